// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared widths, states and field packing for the CAN 2.0A transmit path
package can_pkg;

  localparam int ID_W          = 11;
  localparam int DLC_W         = 4;
  localparam int CRC_W         = 15;
  localparam int CRC_DATA_W    = 83;
  localparam int MAX_STUFF_LEN = 98;

  localparam logic SOF_BIT   = 1'b0;
  localparam logic RECESSIVE = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_CALC,
    S_CAP,
    S_STUFF,
    S_TAIL,
    S_IFS
  } state_t;

  function automatic logic [3:0] payload_bytes(input logic rtr, input logic [DLC_W-1:0] dlc);
    if (rtr) return 4'd0;
    return (dlc > 4'd8) ? 4'd8 : dlc;
  endfunction

  // Right-justified covered field; the zero-cleared CRC engine ignores the leading zeros.
  function automatic logic [CRC_DATA_W-1:0] build_crc_data(input logic [ID_W-1:0]  id,
                                                           input logic             rtr,
                                                           input logic [DLC_W-1:0] dlc,
                                                           input logic [63:0]      data);
    logic [6:0]            nbits;
    logic [CRC_DATA_W-1:0] hdr;
    logic [CRC_DATA_W-1:0] payload;
    nbits   = {payload_bytes(rtr, dlc), 3'b000};
    hdr     = {64'd0, SOF_BIT, id, rtr, 1'b0, 1'b0, dlc};
    payload = {19'd0, data} >> (7'd64 - nbits);
    return (hdr << nbits) | payload;
  endfunction

endpackage

// File: rtl/can_bit_stuffer.sv
// rtl/can_bit_stuffer.sv - registered bit driver that inserts a complement after five equal bits
module can_bit_stuffer
  import can_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic bit_tick,
  input  logic clear,
  input  logic valid,
  input  logic next_bit,
  output logic tx_bit,
  output logic hold
);

  logic       tx_q, tx_d;
  logic [2:0] run_q, run_d;

  assign tx_bit = tx_q;
  assign hold   = (run_q == 3'd5);

  // The run counts transmitted bits, so a stuff bit starts a fresh run of its own value.
  always_comb begin
    tx_d  = tx_q;
    run_d = run_q;
    if (bit_tick) begin
      if (!valid) begin
        tx_d = RECESSIVE;
      end else if (hold) begin
        tx_d  = ~tx_q;
        run_d = 3'd1;
      end else begin
        tx_d  = next_bit;
        run_d = (run_q != 3'd0 && next_bit == tx_q) ? run_q + 3'd1 : 3'd1;
      end
    end
    if (clear) run_d = 3'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q  <= RECESSIVE;
      run_q <= 3'd0;
    end else begin
      tx_q  <= tx_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/can_tx_framer.sv
// rtl/can_tx_framer.sv - CAN 2.0A frame builder: CRC handshake, stuffed serialisation, tail and IFS
module can_tx_framer
  import can_pkg::*;
#(
  parameter int IFS_BITS = 3,
  parameter int EOF_BITS = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit_tick,
  input  logic                  start,
  input  logic [ID_W-1:0]       id,
  input  logic                  rtr,
  input  logic [DLC_W-1:0]      dlc,
  input  logic [63:0]           data,
  output logic [CRC_DATA_W-1:0] crc_data,
  output logic                  crc_clr,
  output logic                  crc_en,
  input  logic [CRC_W-1:0]      crc_in,
  output logic                  tx_bit,
  output logic                  busy,
  output logic                  done
);

  localparam int TAIL_LEN = 10 + EOF_BITS - 7;

  state_t                   state_q, state_d;
  logic [CRC_DATA_W-1:0]    crc_data_q, crc_data_d;
  logic [MAX_STUFF_LEN-1:0] shift_q, shift_d;
  logic [6:0]               idx_q, idx_d;
  logic [6:0]               len_q, len_d;
  logic [3:0]               cnt_q, cnt_d;
  logic                     done_q, done_d;

  logic stuff_valid, stuff_hold, advance;

  // Stay in the stuffed stream while covered/CRC bits remain or a trailing stuff bit is owed.
  assign stuff_valid = (state_q == S_STUFF) && ((idx_q != len_q) || stuff_hold);
  assign advance     = bit_tick && stuff_valid && !stuff_hold;

  assign crc_data = crc_data_q;
  assign crc_clr  = (state_q == S_CLR);
  assign crc_en   = (state_q == S_CALC);
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;

  can_bit_stuffer u_stuffer (
    .clk      (clk),
    .rst      (rst),
    .bit_tick (bit_tick),
    .clear    (state_q == S_CAP),
    .valid    (stuff_valid),
    .next_bit (shift_q[MAX_STUFF_LEN-1]),
    .tx_bit   (tx_bit),
    .hold     (stuff_hold)
  );

  always_comb begin
    state_d    = state_q;
    crc_data_d = crc_data_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          crc_data_d = build_crc_data(id, rtr, dlc, data);
          len_d      = 7'd34 + {payload_bytes(rtr, dlc), 3'b000};
          state_d    = S_CLR;
        end
      end
      S_CLR:  state_d = S_CALC;
      S_CALC: state_d = S_CAP;
      S_CAP: begin
        shift_d = {crc_data_q, crc_in} << (7'(MAX_STUFF_LEN) - len_q);
        idx_d   = 7'd0;
        state_d = S_STUFF;
      end
      S_STUFF: begin
        if (advance) begin
          shift_d = shift_q << 1;
          idx_d   = idx_q + 7'd1;
        end
        // The exit tick already drives the CRC delimiter, the first tail bit.
        if (bit_tick && !stuff_valid) begin
          cnt_d   = 4'd1;
          state_d = S_TAIL;
        end
      end
      S_TAIL: begin
        if (bit_tick) begin
          if (cnt_q == 4'(TAIL_LEN - 1)) begin
            cnt_d   = 4'd0;
            state_d = S_IFS;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_IFS: begin
        if (bit_tick) begin
          if (cnt_q == 4'(IFS_BITS - 1)) begin
            cnt_d   = 4'd0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      crc_data_q <= '0;
      shift_q    <= '0;
      idx_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      crc_data_q <= crc_data_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
    end
  end

endmodule
